// File: rtl/rr_credit_arbiter.sv
// Round-robin arbiter with per-requester burst credits and a transfer lock.
// One registered one-hot grant is held across several accepted transfers.
// Ownership then moves round-robin, with no idle cycle at a handover.
module rr_credit_arbiter #(
  parameter int INPUTS   = 4,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W   = $clog2(INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS-1:0]            req,
  input  logic [INPUTS*WEIGHT_W-1:0]   weight,
  input  logic                         ack,
  input  logic                         lock,
  output logic [INPUTS-1:0]            grant,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         grant_valid
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;
  logic [INPUTS-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic                  valid_q, valid_d;
  logic                  release_s;
  logic [IDX_W-1:0]      next_ptr_s;
  logic [IDX_W-1:0]      pick_s;

  // Lowest requester at or above p; if there is none, wrap to the lowest requester overall.
  function automatic logic [IDX_W-1:0] sel(input logic [IDX_W-1:0] p,
                                           input logic [INPUTS-1:0] r);
    logic             found;
    logic [IDX_W-1:0] res;
    found = 1'b0;
    res   = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (!found && r[i] && (i >= int'(p))) begin
        res   = IDX_W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < INPUTS; i++) begin
      if (!found && r[i]) begin
        res   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // A weight of zero still buys one transfer, so an owner can always make progress.
  function automatic logic [WEIGHT_W-1:0] load_credit(input logic [IDX_W-1:0] idx,
                                                      input logic [INPUTS*WEIGHT_W-1:0] w);
    logic [WEIGHT_W-1:0] v;
    v = w[idx*WEIGHT_W +: WEIGHT_W];
    return (v == '0) ? WEIGHT_W'(1) : v;
  endfunction

  // Next-state logic: grant loading, credit consumption, release and handover.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    credit_d   = credit_q;
    release_s  = 1'b0;
    pick_s     = '0;
    next_ptr_s = (owner_q == IDX_W'(INPUTS - 1)) ? '0 : owner_q + IDX_W'(1);

    case (state_q)
      IDLE: begin
        if (|req) begin
          pick_s   = sel(ptr_q, req);
          state_d  = GRANT;
          owner_d  = pick_s;
          credit_d = load_credit(pick_s, weight);
        end else begin
          state_d  = IDLE;
        end
      end
      GRANT: begin
        // A dropped request releases regardless of ack, lock or remaining credit.
        if (!req[owner_q]) begin
          release_s = 1'b1;
        end else if (ack && (credit_q == WEIGHT_W'(1)) && !lock) begin
          release_s = 1'b1;
        end else if (ack && (credit_q > WEIGHT_W'(1))) begin
          credit_d  = credit_q - WEIGHT_W'(1);
        end else begin
          credit_d  = credit_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handover happens on the release edge itself, so there is no idle bubble.
    if (release_s) begin
      ptr_d = next_ptr_s;
      if (|req) begin
        pick_s   = sel(next_ptr_s, req);
        state_d  = GRANT;
        owner_d  = pick_s;
        credit_d = load_credit(pick_s, weight);
      end else begin
        state_d  = IDLE;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Output values derived from the next state so the outputs are registered.
  always_comb begin
    grant_d     = '0;
    grant_idx_d = '0;
    valid_d     = 1'b0;
    if (state_d == GRANT) begin
      grant_d[owner_d] = 1'b1;
      grant_idx_d      = owner_d;
      valid_d          = 1'b1;
    end else begin
      valid_d          = 1'b0;
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      credit_q    <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      credit_q    <= credit_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      valid_q     <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_credit_arbiter.sv
// Self-checking bench for rr_credit_arbiter: a 4-input and a 3-input instance,
// with expected grants queued as stimulus is driven and compared after each edge.
module tb_rr_credit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        ack, lock;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        grant_valid;

  logic [2:0]  req3;
  logic [11:0] weight3;
  logic        ack3, lock3;
  logic [2:0]  grant3;
  logic [1:0]  grant_idx3;
  logic        grant_valid3;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  logic [2:0] exp3_q[$];

  always #5 clk = ~clk;

  rr_credit_arbiter #(.INPUTS(4), .WEIGHT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .weight(weight), .ack(ack), .lock(lock),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid)
  );

  rr_credit_arbiter #(.INPUTS(3), .WEIGHT_W(4)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .weight(weight3), .ack(ack3), .lock(lock3),
    .grant(grant3), .grant_idx(grant_idx3), .grant_valid(grant_valid3)
  );

  function automatic logic [1:0] enc(input logic [3:0] g);
    enc = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) enc = 2'(i);
  endfunction

  // Pulse reset between clock edges and return all inputs to idle.
  task automatic do_reset;
    #2 rst = 1'b1;
    req = 4'b0000; ack = 1'b0; lock = 1'b0; weight = 16'h0000;
    req3 = 3'b000; ack3 = 1'b0; lock3 = 1'b0; weight3 = 12'h000;
    #3 rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] e;
    total++;
    if (grant !== 4'b0000 || grant_idx !== 2'd0 || grant_valid !== 1'b0) begin
      bad++; $display("FAIL reset4: grant=%b idx=%0d valid=%b required 0/0/0", grant, grant_idx, grant_valid);
    end
    total++;
    if (grant3 !== 3'b000 || grant_idx3 !== 2'd0 || grant_valid3 !== 1'b0) begin
      bad++; $display("FAIL reset3: grant=%b idx=%0d valid=%b required 0/0/0", grant3, grant_idx3, grant_valid3);
    end
    @(posedge clk); #1;
    #5 rst = 1'b0;
    // ack while idle must not produce a grant
    for (int k = 0; k < 2; k++) begin
      req = 4'b0000; ack = 1'b1;
      exp_q.push_back(4'b0000);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (grant !== e || grant_idx !== enc(e) || grant_valid !== (|e)) begin
        bad++; $display("FAIL idle_ack[%0d]: grant=%b valid=%b required grant=%b", k, grant, grant_valid, e);
      end
    end
  endtask

  task automatic test_rotation;
    logic [3:0] e;
    logic [3:0] ex [5];
    ex = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    weight = 16'h1111; req = 4'b1111; ack = 1'b1; lock = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (grant !== e || grant_idx !== enc(e) || grant_valid !== (|e)) begin
        bad++; $display("FAIL rotation[%0d]: grant=%b idx=%0d valid=%b required grant=%b", k, grant, grant_idx, grant_valid, e);
      end
    end
  endtask

  task automatic test_weighted;
    logic [3:0] e;
    logic [3:0] ex [8];
    ex = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    do_reset();
    req = 4'b0110; ack = 1'b1; lock = 1'b0;
    for (int k = 0; k < 8; k++) begin
      // weights change mid-burst from step 5 on; the loaded credit must be unaffected
      weight = (k < 5) ? 16'h0030 : 16'h0000;
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (grant !== e || grant_idx !== enc(e) || grant_valid !== (|e)) begin
        bad++; $display("FAIL weighted[%0d]: grant=%b idx=%0d required grant=%b", k, grant, grant_idx, e);
      end
    end
  endtask

  task automatic test_lock;
    logic [3:0] e;
    logic [3:0] ex [8];
    logic       ak [8];
    logic       lk [8];
    ex = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    ak = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    lk = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    weight = 16'h0002; req = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      ack = ak[k]; lock = lk[k];
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (grant !== e || grant_idx !== enc(e) || grant_valid !== (|e)) begin
        bad++; $display("FAIL lock[%0d]: grant=%b idx=%0d required grant=%b", k, grant, grant_idx, e);
      end
    end
  endtask

  task automatic test_withdraw;
    logic [3:0] e;
    logic [3:0] ex [3];
    logic [3:0] rq [3];
    logic       ak [3];
    logic [1:0] pt [3];
    ex = '{4'b0100, 4'b1000, 4'b0001};
    rq = '{4'b0100, 4'b1001, 4'b1001};
    ak = '{1'b0, 1'b1, 1'b1};
    pt = '{2'd0, 2'd3, 2'd0};
    do_reset();
    weight = 16'h0500; lock = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req = rq[k]; ack = ak[k];
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (grant !== e || grant_idx !== enc(e) || grant_valid !== (|e)) begin
        bad++; $display("FAIL withdraw[%0d]: grant=%b idx=%0d required grant=%b", k, grant, grant_idx, e);
      end
      total++;
      if (dut.ptr_q !== pt[k]) begin
        bad++; $display("FAIL withdraw_ptr[%0d]: ptr=%0d required %0d", k, dut.ptr_q, pt[k]);
      end
    end
  endtask

  task automatic test_sole_wrap;
    logic [2:0] e;
    logic [2:0] ex [8];
    logic [2:0] rq [8];
    ex = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    rq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b111, 3'b111, 3'b111, 3'b111};
    do_reset();
    weight3 = 12'h111; ack3 = 1'b1; lock3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      req3 = rq[k];
      exp3_q.push_back(ex[k]);
      @(posedge clk); #1;
      e = exp3_q.pop_front();
      total++;
      if (grant3 !== e || grant_valid3 !== 1'b1 || grant_idx3 !== enc({1'b0, e})) begin
        bad++; $display("FAIL sole_wrap[%0d]: grant=%b idx=%0d required grant=%b", k, grant3, grant_idx3, e);
      end
      // releases of owner 2 wrap the pointer to 0; the pointer stays below 3
      total++;
      if ((k < 4 && dut3.ptr_q !== 2'd0) || dut3.ptr_q > 2'd2) begin
        bad++; $display("FAIL sole_ptr[%0d]: ptr=%0d", k, dut3.ptr_q);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] e;
    do_reset();
    weight = 16'h0400; req = 4'b0100; lock = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ack = (k == 1);
      exp_q.push_back(4'b0100);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (grant !== e || grant_idx !== enc(e) || grant_valid !== 1'b1) begin
        bad++; $display("FAIL pre_reset[%0d]: grant=%b required %b", k, grant, e);
      end
    end
    total++;
    if (dut.credit_q !== 4'd3) begin
      bad++; $display("FAIL pre_reset_credit: credit=%0d required 3", dut.credit_q);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (grant !== 4'b0000 || grant_idx !== 2'd0 || grant_valid !== 1'b0 || dut.ptr_q !== 2'd0 || dut.credit_q !== 4'd0) begin
      bad++; $display("FAIL async_reset: grant=%b idx=%0d valid=%b ptr=%0d credit=%0d required all 0", grant, grant_idx, grant_valid, dut.ptr_q, dut.credit_q);
    end
    #2 rst = 1'b0;
    exp_q.push_back(4'b0100);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (grant !== e || grant_idx !== 2'd2 || grant_valid !== 1'b1 || dut.ptr_q !== 2'd0 || dut.credit_q !== 4'd4) begin
      bad++; $display("FAIL post_reset: grant=%b idx=%0d ptr=%0d credit=%0d required 0100/2/0/4", grant, grant_idx, dut.ptr_q, dut.credit_q);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000; ack = 1'b0; lock = 1'b0; weight = 16'h0000;
    req3 = 3'b000; ack3 = 1'b0; lock3 = 1'b0; weight3 = 12'h000;
    #1;
    test_reset();
    test_rotation();
    test_weighted();
    test_lock();
    test_withdraw();
    test_sole_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
